// File: rtl/rom_arbiter_if.sv
// Bundle of the two read-request ports, the ROM-side bus and the busy flag
// of the ROM arbiter. The arbiter uses the slave side; requesters and the ROM
// sit on the master side.
interface rom_arbiter_if;
  logic       req0;
  logic [2:0] idx0;
  logic       gnt0;
  logic       rvalid0;
  logic [7:0] rdata0;

  logic       req1;
  logic [2:0] idx1;
  logic       gnt1;
  logic       rvalid1;
  logic [7:0] rdata1;

  logic       rom_enable;
  logic [7:0] rom_address;
  logic [7:0] rom_data;

  logic       busy;

  modport slave (
    input  req0, idx0, req1, idx1, rom_data,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
           rom_enable, rom_address, busy
  );

  modport master (
    output req0, idx0, req1, idx1, rom_data,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
           rom_enable, rom_address, busy
  );
endinterface

// File: rtl/rom_arbiter.sv
// Two-port round-robin arbiter in front of an 8-entry ROM with one-hot
// addressing and a registered output. One read takes three cycles:
// grant/issue, ROM sample, capture. Every output comes straight from a flop.
module rom_arbiter (
  input  logic         clk,
  input  logic         rst,
  rom_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t     state_reg, state_next;
  logic       gnt0_reg, gnt0_next;
  logic       gnt1_reg, gnt1_next;
  logic       rvalid0_reg, rvalid0_next;
  logic       rvalid1_reg, rvalid1_next;
  logic [7:0] rdata0_reg, rdata0_next;
  logic [7:0] rdata1_reg, rdata1_next;
  logic       rom_enable_reg, rom_enable_next;
  logic [7:0] rom_address_reg, rom_address_next;
  logic       busy_reg, busy_next;
  // Port currently being served (0/1).
  logic       winner_reg, winner_next;
  // Last-served port; reset to 1 so that port 0 wins the first contention.
  logic       last_reg, last_next;
  logic       win;

  // State and output registers; reset aborts any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      gnt0_reg        <= 1'b0;
      gnt1_reg        <= 1'b0;
      rvalid0_reg     <= 1'b0;
      rvalid1_reg     <= 1'b0;
      rdata0_reg      <= 8'h00;
      rdata1_reg      <= 8'h00;
      rom_enable_reg  <= 1'b0;
      rom_address_reg <= 8'h00;
      busy_reg        <= 1'b0;
      winner_reg      <= 1'b0;
      last_reg        <= 1'b1;
    end else begin
      state_reg       <= state_next;
      gnt0_reg        <= gnt0_next;
      gnt1_reg        <= gnt1_next;
      rvalid0_reg     <= rvalid0_next;
      rvalid1_reg     <= rvalid1_next;
      rdata0_reg      <= rdata0_next;
      rdata1_reg      <= rdata1_next;
      rom_enable_reg  <= rom_enable_next;
      rom_address_reg <= rom_address_next;
      busy_reg        <= busy_next;
      winner_reg      <= winner_next;
      last_reg        <= last_next;
    end
  end

  // Next-state and next-output logic; pulses default low, data holds.
  always_comb begin
    state_next       = state_reg;
    gnt0_next        = 1'b0;
    gnt1_next        = 1'b0;
    rvalid0_next     = 1'b0;
    rvalid1_next     = 1'b0;
    rdata0_next      = rdata0_reg;
    rdata1_next      = rdata1_reg;
    rom_enable_next  = 1'b0;
    rom_address_next = 8'h00;
    busy_next        = 1'b0;
    winner_next      = winner_reg;
    last_next        = last_reg;
    // Contention goes to the port not served last; a sole requester wins.
    win = (bus.req0 && bus.req1) ? ~last_reg : bus.req1;

    case (state_reg)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          winner_next      = win;
          last_next        = win;
          gnt0_next        = ~win;
          gnt1_next        = win;
          rom_enable_next  = 1'b1;
          // The index is captured here as the one-hot address; later idx
          // changes are not looked at until the next grant.
          rom_address_next = 8'd1 << (win ? bus.idx1 : bus.idx0);
          busy_next        = 1'b1;
          state_next       = ISSUE;
        end
      end
      ISSUE: begin
        // The ROM samples enable/address on this edge; drop them now.
        busy_next  = 1'b1;
        state_next = CAPTURE;
      end
      CAPTURE: begin
        if (winner_reg) begin
          rdata1_next  = bus.rom_data;
          rvalid1_next = 1'b1;
        end else begin
          rdata0_next  = bus.rom_data;
          rvalid0_next = 1'b1;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.gnt0        = gnt0_reg;
  assign bus.gnt1        = gnt1_reg;
  assign bus.rvalid0     = rvalid0_reg;
  assign bus.rvalid1     = rvalid1_reg;
  assign bus.rdata0      = rdata0_reg;
  assign bus.rdata1      = rdata1_reg;
  assign bus.rom_enable  = rom_enable_reg;
  assign bus.rom_address = rom_address_reg;
  assign bus.busy        = busy_reg;

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL provide these ports:
- clk  in  1  rising-edge clock, single domain
- rst  in  1  synchronous, active-high reset
- req0  in  1  port-0 read request, level, held until gnt0
- idx0  in  3  port-0 ROM index (0..7)
- gnt0  out  1  port-0 grant, one-cycle pulse
- rvalid0  out  1  port-0 read data valid, one-cycle pulse
- rdata0  out  8  port-0 read data
- req1, idx1, gnt1, rvalid1, rdata1  (same as port 0, for port 1)
- rom_enable  out  1  ROM enable
- rom_address  out  8  ROM address, one-hot
- rom_data  in  8  ROM registered output
- busy  out  1  high whenever state is not IDLE

REQ-002 SHALL treat clk as the only clock and rst as synchronous and active-high.

Function
REQ-003 SHALL register all outputs, with no combinational path from any input to any output.
REQ-004 SHALL implement a three-state FSM: IDLE, ISSUE, CAPTURE.
REQ-005 SHALL, in IDLE with no request, hold rom_enable=0 and rom_address=8'h00.
REQ-006 SHALL, in IDLE with any req high at edge N, do all of the following at edge N:
- select a winner
- set the winner's gnt=1
- latch the winner's idx
- set rom_enable=1 and rom_address=1<<idx
- move to ISSUE
REQ-007 SHALL, in ISSUE at edge N+1, set rom_enable=0, set rom_address=8'h00, clear gnt, and move to CAPTURE; the ROM samples the read on this edge.
REQ-008 SHALL, in CAPTURE at edge N+2, capture rom_data into the winner's rdata, pulse its rvalid for one cycle, and return to IDLE.
REQ-009 SHALL deliver read latency of 2 cycles from grant to rvalid, and SHALL accept the next grant no earlier than edge N+3 (one read per 3 cycles).
REQ-010 SHALL hold rdataX stable between its rvalidX pulses, and SHALL never change rdata on the other port.
REQ-011 SHALL arbitrate round-robin using a last-served pointer:
- sole requester wins
- when both request, the port not last served wins
- after reset, port 0 is preferred
REQ-012 SHALL update the last-served pointer only on a grant.
REQ-013 SHALL ignore req and idx changes while busy; idx is used only as latched at the grant edge.
REQ-014 SHALL let a requester keep req high after gnt to request another read, which is then arbitrated normally in the next IDLE.
REQ-015 SHALL never assert gnt0 and gnt1 together, nor rvalid0 and rvalid1 together.
REQ-016 SHALL keep rom_address one-hot or zero at all times, and nonzero only while rom_enable=1.
REQ-017 SHALL drive busy=1 in ISSUE and CAPTURE.

Reset
REQ-018 SHALL, with rst high at an edge, force all of the following at that edge, from any state including mid-read:
- state=IDLE
- gnt0/1=0, rvalid0/1=0
- rdata0/1=8'h00
- rom_enable=0, rom_address=8'h00
- busy=0
- pointer = prefer port 0
REQ-019 SHALL NOT produce an rvalid for a read aborted by reset.
REQ-020 SHALL honour rst over every other input in the same cycle.

Verification
ROM contents for indices 0..7: A3 5C F1 2B 7E D9 4A B6.

REQ-021 SHALL cover: req0=1, idx0=2, req1=0 -> gnt0 at edge N, rom_address=8'h04 with rom_enable=1 during ISSUE, rvalid0 with rdata0=8'hF1 at N+2.
REQ-022 SHALL cover: req0 and req1 both held, idx0=0, idx1=5 -> grants alternate 0,1,0,1; rdata0=8'hA3 and rdata1=8'hD9 alternately; rvalids 3 cycles apart.
REQ-023 SHALL cover: req1=1, idx1=7, idx1 changed to 3 during ISSUE -> rdata1=8'hB6, and the change is ignored.
REQ-024 SHALL cover: rst asserted in CAPTURE of a port-0 read -> no rvalid0, all outputs zero next cycle; next simultaneous request grants port 0.
REQ-025 SHALL cover: no requests for 10 cycles -> rom_enable=0, rom_address=8'h00, busy=0, and no gnt/rvalid throughout.
REQ-026 SHALL cover: port-0 reads of every idx 0..7 -> rdata0 matches the ROM table, and rom_address is one-hot (1<<idx) for every read.
